cmd_resp_tx: RTL and testbench

CMD_RESP_TX -- requirements
Module: cmd_resp_tx

---
 rtl/cmd_resp_tx.sv | 112 +++++++++++
 tb/tb_cmd_resp_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_resp_tx.sv
// Command reply transmitter: turns accepted-command pulses into ASCII replies
// ("RUN", "CLR", "MOD" plus line ending) pushed one character per cycle into a TX FIFO.
module cmd_resp_tx #(
    parameter bit EN_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_evt_run,
    input  logic       i_evt_clear,
    input  logic       i_evt_mode,
    input  logic       tx_full,
    output logic       tx_push,
    output logic [7:0] tx_data,
    output logic       o_busy
);

    localparam logic [2:0] LastIdx = EN_CRLF ? 3'd4 : 3'd3;

    typedef enum logic {StIdle, StSend} state_e;
    typedef enum logic [1:0] {MsgRun, MsgClr, MsgMod} msg_e;

    state_e     state_q, state_d;
    msg_e       msg_q, msg_d;
    logic [2:0] idx_q, idx_d;
    logic       pend_run_q, pend_clr_q, pend_mode_q;
    logic       pend_run_d, pend_clr_d, pend_mode_d;
    logic       take_run, take_clr, take_mode;

    function automatic logic [7:0] char_at(input msg_e msg, input logic [2:0] idx);
        logic [23:0] word;
        unique case (msg)
            MsgRun:  word = 24'h52554E;
            MsgClr:  word = 24'h434C52;
            default: word = 24'h4D4F44;
        endcase
        case (idx)
            3'd0:    return word[23:16];
            3'd1:    return word[15:8];
            3'd2:    return word[7:0];
            3'd3:    return EN_CRLF ? 8'h0D : 8'h0A;
            3'd4:    return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        idx_d     = idx_q;
        take_run  = 1'b0;
        take_clr  = 1'b0;
        take_mode = 1'b0;
        tx_push   = 1'b0;
        tx_data   = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (pend_run_q) begin
                    take_run = 1'b1;
                    msg_d    = MsgRun;
                end else if (pend_clr_q) begin
                    take_clr = 1'b1;
                    msg_d    = MsgClr;
                end else if (pend_mode_q) begin
                    take_mode = 1'b1;
                    msg_d     = MsgMod;
                end
                if (pend_run_q | pend_clr_q | pend_mode_q) begin
                    idx_d   = 3'd0;
                    state_d = StSend;
                end
            end
            StSend: begin
                tx_push = ~tx_full;
                tx_data = char_at(msg_q, idx_q);
                if (tx_push) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = 3'd0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A fresh event outranks the clear of its own flag, so the reply is queued again.
        pend_run_d  = i_evt_run   | (pend_run_q  & ~take_run);
        pend_clr_d  = i_evt_clear | (pend_clr_q  & ~take_clr);
        pend_mode_d = i_evt_mode  | (pend_mode_q & ~take_mode);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            msg_q       <= MsgRun;
            idx_q       <= 3'd0;
            pend_run_q  <= 1'b0;
            pend_clr_q  <= 1'b0;
            pend_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            msg_q       <= msg_d;
            idx_q       <= idx_d;
            pend_run_q  <= pend_run_d;
            pend_clr_q  <= pend_clr_d;
            pend_mode_q <= pend_mode_d;
        end
    end

    assign o_busy = (state_q != StIdle) | pend_run_q | pend_clr_q | pend_mode_q;

endmodule

// File: tb/tb_cmd_resp_tx.sv
// Bench for cmd_resp_tx: CRLF and LF-only instances share stimulus and are compared
// every cycle against a queue-based reply model, plus directed timing scenarios.
module tb_cmd_resp_tx;

    localparam int LogLen = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       evt_run, evt_clear, evt_mode, tx_full;
    logic       push_a, push_b, busy_a, busy_b;
    logic [7:0] data_a, data_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic       push_log[2][LogLen];
    logic [7:0] data_log[2][LogLen];
    logic       busy_log[2][LogLen];

    // Reference model: remaining characters of the reply on the wire and pending set.
    logic [7:0] cur_q[2][$];
    logic [2:0] pend_m[2];

    always #5 clk = ~clk;

    cmd_resp_tx #(.EN_CRLF(1'b1)) dut_a (
        .clk(clk), .rst(rst), .i_evt_run(evt_run), .i_evt_clear(evt_clear),
        .i_evt_mode(evt_mode), .tx_full(tx_full), .tx_push(push_a), .tx_data(data_a),
        .o_busy(busy_a)
    );

    cmd_resp_tx #(.EN_CRLF(1'b0)) dut_b (
        .clk(clk), .rst(rst), .i_evt_run(evt_run), .i_evt_clear(evt_clear),
        .i_evt_mode(evt_mode), .tx_full(tx_full), .tx_push(push_b), .tx_data(data_b),
        .o_busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] letter(input int k, input int j);
        logic [23:0] w;
        case (k)
            0:       w = 24'h52554E;
            1:       w = 24'h434C52;
            default: w = 24'h4D4F44;
        endcase
        return w[23-8*j -: 8];
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                cur_q[i].delete();
                pend_m[i] = 3'b000;
            end else begin
                if (cur_q[i].size() > 0) begin
                    if (!tx_full) void'(cur_q[i].pop_front());
                end else if (pend_m[i] != 3'b000) begin
                    int k;
                    k = pend_m[i][0] ? 0 : (pend_m[i][1] ? 1 : 2);
                    for (int j = 0; j < 3; j++) cur_q[i].push_back(letter(k, j));
                    if (i == 0) cur_q[i].push_back(8'h0D);
                    cur_q[i].push_back(8'h0A);
                    pend_m[i][k] = 1'b0;
                end
                pend_m[i] = pend_m[i] | {evt_mode, evt_clear, evt_run};
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic       ep, eb, gp, gb;
            logic [7:0] ed, gd;
            ep = (cur_q[i].size() > 0) && !tx_full;
            ed = (cur_q[i].size() > 0) ? cur_q[i][0] : 8'h00;
            eb = (cur_q[i].size() > 0) || (pend_m[i] != 3'b000);
            gp = (i == 0) ? push_a : push_b;
            gd = (i == 0) ? data_a : data_b;
            gb = (i == 0) ? busy_a : busy_b;
            check_eq($sformatf("model_push%0d", i), {31'd0, gp}, {31'd0, ep});
            check_eq($sformatf("model_data%0d", i), {24'd0, gd}, {24'd0, ed});
            check_eq($sformatf("model_busy%0d", i), {31'd0, gb}, {31'd0, eb});
            if (cyc < LogLen) begin
                push_log[i][cyc] = gp;
                data_log[i][cyc] = gd;
                busy_log[i][cyc] = gb;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic r, input logic c, input logic m);
        evt_run = r; evt_clear = c; evt_mode = m;
        step();
        evt_run = 1'b0; evt_clear = 1'b0; evt_mode = 1'b0;
    endtask

    function automatic int pushes(input int i, input int from, input int to);
        int n = 0;
        for (int c = from; c <= to; c++) if (push_log[i][c]) n++;
        return n;
    endfunction

    logic [7:0] crlf_run[5];
    logic [7:0] lf_clr[4];

    initial begin
        int p;
        crlf_run = '{8'h52, 8'h55, 8'h4E, 8'h0D, 8'h0A};
        lf_clr   = '{8'h43, 8'h4C, 8'h52, 8'h0A};
        rst = 1'b0; evt_run = 1'b0; evt_clear = 1'b0; evt_mode = 1'b0; tx_full = 1'b0;
        step(3);
        check_eq("rst_push", {31'd0, push_a}, 32'd0);
        check_eq("rst_data", {24'd0, data_a}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        rst = 1'b1;
        while (cyc < 10) step();

        // Single run reply with CR LF
        p = cyc;
        pulse(1'b1, 1'b0, 1'b0);
        step(12);
        check_eq("run_nopush_early", {31'd0, push_log[0][p+1]}, 32'd0);
        for (int j = 0; j < 5; j++) begin
            check_eq("run_push", {31'd0, push_log[0][p+2+j]}, 32'd1);
            check_eq("run_data", {24'd0, data_log[0][p+2+j]}, {24'd0, crlf_run[j]});
        end
        check_eq("run_busy_end", {31'd0, busy_log[0][p+7]}, 32'd0);
        step(10);

        // LF-only clear reply
        p = cyc;
        pulse(1'b0, 1'b1, 1'b0);
        step(14);
        check_eq("lf_count", pushes(1, p, p + 14), 32'd4);
        for (int j = 0; j < 4; j++)
            check_eq("lf_data", {24'd0, data_log[1][p+2+j]}, {24'd0, lf_clr[j]});
        step(5);

        // All three at once: priority order with one idle cycle between replies
        p = cyc;
        pulse(1'b1, 1'b1, 1'b1);
        step(28);
        check_eq("all_count", pushes(0, p, p + 28), 32'd15);
        check_eq("all_gap1", {31'd0, push_log[0][p+7]}, 32'd0);
        check_eq("all_gap2", {31'd0, push_log[0][p+13]}, 32'd0);
        check_eq("all_clr0", {24'd0, data_log[0][p+8]}, 32'h43);
        check_eq("all_mod0", {24'd0, data_log[0][p+14]}, 32'h4D);
        check_eq("all_mod_end", {24'd0, data_log[0][p+18]}, 32'h0A);

        // Back-pressure on the 2nd character of CLR
        p = cyc;
        pulse(1'b0, 1'b1, 1'b0);
        while (cyc < p + 3) step();
        tx_full = 1'b1;
        step(3);
        tx_full = 1'b0;
        step(10);
        for (int j = 3; j < 6; j++) begin
            check_eq("full_nopush", {31'd0, push_log[0][p+j]}, 32'd0);
            check_eq("full_hold", {24'd0, data_log[0][p+j]}, 32'h4C);
        end
        check_eq("full_count", pushes(0, p, p + 15), 32'd5);
        check_eq("full_resume", {24'd0, data_log[0][p+6]}, 32'h4C);
        check_eq("full_next", {24'd0, data_log[0][p+7]}, 32'h52);

        // Two clears during a run reply merge into one
        p = cyc;
        pulse(1'b1, 1'b0, 1'b0);
        step(2);
        pulse(1'b0, 1'b1, 1'b0);
        step();
        pulse(1'b0, 1'b1, 1'b0);
        step(25);
        check_eq("merge_count", pushes(0, p, p + 28), 32'd10);
        check_eq("merge_clr0", {24'd0, data_log[0][p+8]}, 32'h43);
        check_eq("merge_idle", {31'd0, busy_log[0][p+14]}, 32'd0);

        // Reset mid-reply with a run pending
        p = cyc;
        pulse(1'b0, 1'b0, 1'b1);
        step(2);
        pulse(1'b1, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check_eq("rstmid_push", {31'd0, push_a}, 32'd0);
        check_eq("rstmid_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rstmid_data", {24'd0, data_a}, 32'd0);
        step(2);
        rst = 1'b1;
        step(20);
        check_eq("rstmid_quiet", pushes(0, p + 5, cyc - 1), 32'd0);

        // Randomized traffic, including occasional resets
        repeat (1500) begin
            evt_run   = ($urandom_range(0, 9) == 0);
            evt_clear = ($urandom_range(0, 9) == 0);
            evt_mode  = ($urandom_range(0, 9) == 0);
            tx_full   = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 299) != 0);
            step();
        end
        rst = 1'b1; evt_run = 1'b0; evt_clear = 1'b0; evt_mode = 1'b0; tx_full = 1'b0;
        step(30);
        check_eq("final_idle_a", {31'd0, busy_a}, 32'd0);
        check_eq("final_idle_b", {31'd0, busy_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
